// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        STOP2  = 3'd5
    } rx_state_e;

    // Encoding 3 is treated as "no parity", the same as 0.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_RSVD = 2'd3
    } parity_mode_e;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser, per-bit tick counter and 3-sample majority voter.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic cnt_clr,
    output logic rx_s,
    output logic fall_edge,
    output logic bit_strobe,
    output logic bit_val
);

    localparam int unsigned     CNT_W     = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] TICK_LO   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] TICK_MID  = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] TICK_HI   = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] TICK_WRAP = CNT_W'(OVERSAMPLE - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             smp_lo_q, smp_lo_d;
    logic             smp_mid_q, smp_mid_d;

    // Next-state: shift the synchroniser, advance the tick counter, capture early votes.
    always_comb begin
        sync1_d   = rx;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        smp_lo_d  = smp_lo_q;
        smp_mid_d = smp_mid_q;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_clr || (cnt_q == TICK_WRAP)) begin
            cnt_d = '0;
        end
        if (cnt_q == TICK_LO) begin
            smp_lo_d = sync2_q;
        end
        if (cnt_q == TICK_MID) begin
            smp_mid_d = sync2_q;
        end
    end

    // Registers; synchroniser resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            cnt_q     <= '0;
            smp_lo_q  <= 1'b0;
            smp_mid_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            smp_lo_q  <= smp_lo_d;
            smp_mid_q <= smp_mid_d;
        end
    end

    assign rx_s       = sync2_q;
    assign fall_edge  = prev_q & ~sync2_q;
    assign bit_strobe = (cnt_q == TICK_HI);
    assign bit_val    = majority3(smp_lo_q, smp_mid_q, sync2_q);

endmodule

// File: rtl/uart_rx_param.sv
// UART receive engine: frame FSM, shift register and handshaked holding register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_en,
    input  logic                 rx,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 break_det
);

    localparam int unsigned          BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);

    logic rx_s, fall_edge, bit_strobe, bit_val, cnt_clr_c;

    rx_state_e              state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    parity_mode_e           par_mode_q, par_mode_d;
    logic                   two_stop_q, two_stop_d;
    logic                   par_bit_q, par_bit_d;
    logic                   par_err_acc_q, par_err_acc_d;
    logic                   frm_err_acc_q, frm_err_acc_d;
    logic                   stop_hi_q, stop_hi_d;

    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   data_valid_q, data_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   break_q, break_d;
    logic                   busy_q, busy_d;

    logic complete_c, accept_c, frm_err_c, brk_c;

    // Counter is held at zero while idle so START begins on tick 0.
    assign cnt_clr_c = (state_q == IDLE);

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .cnt_clr    (cnt_clr_c),
        .rx_s       (rx_s),
        .fall_edge  (fall_edge),
        .bit_strobe (bit_strobe),
        .bit_val    (bit_val)
    );

    // Frame sequencing, frame-level error tracking and holding register update.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_mode_d    = par_mode_q;
        two_stop_d    = two_stop_q;
        par_bit_d     = par_bit_q;
        par_err_acc_d = par_err_acc_q;
        frm_err_acc_d = frm_err_acc_q;
        stop_hi_d     = stop_hi_q;
        data_d        = data_q;
        data_valid_d  = data_valid_q;
        parity_err_d  = parity_err_q;
        frame_err_d   = frame_err_q;
        overrun_d     = overrun_q;
        break_d       = 1'b0;
        complete_c    = 1'b0;
        accept_c      = data_valid_q & data_ready;
        frm_err_c     = frm_err_acc_q | ~bit_val;
        brk_c         = (shift_q == '0) && !((par_mode_q != PAR_NONE) && par_bit_q)
                        && !(stop_hi_q || bit_val);

        unique case (state_q)
            IDLE: begin
                if (rx_en && fall_edge && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_strobe) begin
                    if (!bit_val) begin
                        state_d       = DATA;
                        bit_cnt_d     = '0;
                        par_mode_d    = parity_enabled(parity_mode) ? parity_mode_e'(parity_mode)
                                                                    : PAR_NONE;
                        two_stop_d    = stop_bits;
                        par_bit_d     = 1'b0;
                        par_err_acc_d = 1'b0;
                        frm_err_acc_d = 1'b0;
                        stop_hi_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (bit_strobe) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (par_mode_q == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_strobe) begin
                    par_bit_d     = bit_val;
                    par_err_acc_d = (bit_val ^ (^shift_q)) ^ (par_mode_q == PAR_ODD);
                    state_d       = STOP;
                end
            end
            STOP: begin
                if (bit_strobe) begin
                    frm_err_acc_d = frm_err_c;
                    stop_hi_d     = stop_hi_q | bit_val;
                    if (two_stop_q) begin
                        state_d = STOP2;
                    end else begin
                        complete_c = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            STOP2: begin
                if (bit_strobe) begin
                    complete_c = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disabling the receiver drops any partial frame and clears the sticky overrun.
        if (!rx_en) begin
            state_d    = IDLE;
            complete_c = 1'b0;
        end

        if (accept_c) begin
            data_valid_d = 1'b0;
        end
        if (complete_c) begin
            data_d       = shift_q;
            parity_err_d = par_err_acc_q;
            frame_err_d  = frm_err_c;
            data_valid_d = 1'b1;
            break_d      = brk_c;
            if (data_valid_q && !accept_c) begin
                overrun_d = 1'b1;
            end
        end
        if (!rx_en) begin
            overrun_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_mode_q    <= PAR_NONE;
            two_stop_q    <= 1'b0;
            par_bit_q     <= 1'b0;
            par_err_acc_q <= 1'b0;
            frm_err_acc_q <= 1'b0;
            stop_hi_q     <= 1'b0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
            break_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_mode_q    <= par_mode_d;
            two_stop_q    <= two_stop_d;
            par_bit_q     <= par_bit_d;
            par_err_acc_q <= par_err_acc_d;
            frm_err_acc_q <= frm_err_acc_d;
            stop_hi_q     <= stop_hi_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
            break_q       <= break_d;
            busy_q        <= busy_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = data_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign break_det   = break_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param (8 data bits, 16x oversampling).
module tb_uart_rx_param;

    localparam int unsigned DW = 8;
    localparam int unsigned OS = 16;

    logic          clk = 1'b0;
    logic          rst_n, rx_en, rx, stop_bits, data_ready;
    logic [1:0]    parity_mode;
    logic [DW-1:0] data_out;
    logic          data_valid, busy, parity_err, frame_err, overrun_err, break_det;

    int n_assert = 0;
    int n_fail   = 0;
    int brk_cnt  = 0;
    int lat;

    typedef struct {
        logic [7:0] data;
        logic [1:0] pmode;
        logic       pbit;
        logic       two;
        logic       s1;
        logic       s2;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    vec_t vecs [10];

    uart_rx_param #(
        .DATA_BITS  (DW),
        .OVERSAMPLE (OS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_en       (rx_en),
        .rx          (rx),
        .parity_mode (parity_mode),
        .stop_bits   (stop_bits),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .busy        (busy),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .break_det   (break_det)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (break_det === 1'b1) brk_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Frame-level reference: what the receiver should report for a given line frame.
    function automatic exp_t ref_model(input logic [7:0] d, input logic [1:0] pm, input logic pb,
                                       input logic two, input logic s1, input logic s2);
        exp_t e;
        int   ones;
        logic par_en;
        par_en = (pm == 2'd1) || (pm == 2'd2);
        ones   = $countones(d) + int'(pb);
        e.d    = d;
        e.perr = par_en ? ((pm == 2'd1) ? (ones % 2 == 1) : (ones % 2 == 0)) : 1'b0;
        e.ferr = !s1 || (two && !s2);
        e.brk  = (d == 8'h00) && (!par_en || !pb) && !s1 && (!two || !s2);
        return e;
    endfunction

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (OS) @(negedge clk);
    endtask

    // Drives one frame on rx; called and returns at a negedge.
    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic pb,
                              input logic two, input logic s1, input logic s2);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (par_en) drive_bit(pb);
        drive_bit(s1);
        if (two) drive_bit(s2);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic consume();
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] pm,
                             input logic pb, input logic two, input logic s1, input logic s2,
                             input logic [7:0] ed, input logic ep, input logic ef, input logic eb);
        int b0;
        parity_mode = pm;
        stop_bits   = two;
        b0          = brk_cnt;
        send_frame(d, (pm == 2'd1) || (pm == 2'd2), pb, two, s1, s2);
        check({tag, " valid"}, data_valid, 1);
        check({tag, " data"}, data_out, ed);
        check({tag, " parity_err"}, parity_err, ep);
        check({tag, " frame_err"}, frame_err, ef);
        check({tag, " break_pulses"}, brk_cnt - b0, eb);
        check({tag, " overrun"}, overrun_err, 0);
        consume();
        check({tag, " valid_after_accept"}, data_valid, 0);
        idle(4);
    endtask

    initial begin
        exp_t e;
        logic saw_busy, saw_valid;
        logic [7:0] d;
        logic [1:0] pm;
        logic pb, two, s1, s2;

        //             data   pm    pb    two   s1    s2    exp    perr  ferr  brk
        vecs[0] = '{8'h55, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hA5, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'hA5, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{8'h00, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{8'hFF, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{8'h81, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; rx_en = 1'b1; rx = 1'b1; stop_bits = 1'b0;
        parity_mode = 2'd0; data_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst data_out", data_out, 0);
        check("rst data_valid", data_valid, 0);
        check("rst busy", busy, 0);
        check("rst parity_err", parity_err, 0);
        check("rst frame_err", frame_err, 0);
        check("rst overrun", overrun_err, 0);
        check("rst break_det", break_det, 0);
        rst_n = 1'b1;
        idle(5);

        // Start edge to data_valid latency, counted from the first clk that samples rx low.
        fork
            send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            begin
                @(posedge clk);
                #1;
                lat = 0;
                while (data_valid !== 1'b1 && lat < 400) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        check("latency", lat, 156);
        check("lat data", data_out, 8'h55);
        check("lat errs", {parity_err, frame_err, overrun_err}, 0);
        consume();
        idle(4);

        for (int i = 0; i < 10; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].pmode, vecs[i].pbit,
                      vecs[i].two, vecs[i].s1, vecs[i].s2, vecs[i].exp_data,
                      vecs[i].exp_perr, vecs[i].exp_ferr, vecs[i].exp_brk);
        end

        // Config changes mid-frame must not affect the frame in flight.
        parity_mode = 2'd1; stop_bits = 1'b0;
        fork
            send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            begin
                repeat (4 * OS) @(negedge clk);
                parity_mode = 2'd0;
                stop_bits   = 1'b1;
            end
        join
        check("cfg valid", data_valid, 1);
        check("cfg data", data_out, 8'hA5);
        check("cfg parity_err", parity_err, 1);
        check("cfg frame_err", frame_err, 0);
        parity_mode = 2'd0; stop_bits = 1'b0;
        consume();
        idle(4);

        // Short low glitch on an idle line is a false start.
        saw_busy = 1'b0; saw_valid = 1'b0;
        for (int i = 0; i < 46; i++) begin
            rx = (i < 6) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (busy === 1'b1) saw_busy = 1'b1;
            if (data_valid === 1'b1) saw_valid = 1'b1;
        end
        check("glitch saw_busy", saw_busy, 1);
        check("glitch busy_end", busy, 0);
        check("glitch no_valid", saw_valid, 0);

        // Back-to-back frames without consuming.
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ovr valid", data_valid, 1);
        check("ovr data", data_out, 8'h22);
        check("ovr flag", overrun_err, 1);
        consume();
        check("ovr valid_after_accept", data_valid, 0);
        check("ovr sticky", overrun_err, 1);
        idle(4);

        // Receiver disabled at data bit 4.
        fork
            send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            begin
                repeat (5 * OS + 8) @(negedge clk);
                check("abort busy_before", busy, 1);
                rx_en = 1'b0;
                @(posedge clk);
                #1;
                check("abort busy", busy, 0);
                check("abort overrun_clr", overrun_err, 0);
            end
        join
        check("abort no_valid", data_valid, 0);
        rx_en = 1'b1;
        idle(20);
        check("abort idle_busy", busy, 0);
        check("abort idle_valid", data_valid, 0);

        // Completion and accept in the same cycle.
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("same first_valid", data_valid, 1);
        idle(4);
        fork
            send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            begin
                @(posedge clk);
                repeat (155) @(posedge clk);
                #1 data_ready = 1'b1;
                @(posedge clk);
                #1 data_ready = 1'b0;
                check("same valid", data_valid, 1);
                check("same data", data_out, 8'hC3);
                check("same overrun", overrun_err, 0);
            end
        join
        consume();
        idle(4);

        // Randomised frames against the reference model.
        for (int i = 0; i < 30; i++) begin
            d   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) d = 8'h00;
            pm  = 2'($urandom_range(0, 3));
            pb  = 1'($urandom_range(0, 1));
            two = 1'($urandom_range(0, 1));
            s1  = ($urandom_range(0, 3) != 0);
            s2  = ($urandom_range(0, 3) != 0);
            e   = ref_model(d, pm, pb, two, s1, s2);
            run_frame($sformatf("rnd%0d", i), d, pm, pb, two, s1, s2, e.d, e.perr, e.ferr, e.brk);
        end
        parity_mode = 2'd0; stop_bits = 1'b0;

        // Asynchronous reset in the middle of a frame while a word is held.
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("arst held_valid", data_valid, 1);
        fork
            send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            begin
                repeat (40) @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("arst data_out", data_out, 0);
                check("arst valid", data_valid, 0);
                check("arst busy", busy, 0);
                check("arst errs", {parity_err, frame_err, overrun_err, break_det}, 0);
            end
        join
        rst_n = 1'b1;
        idle(10);
        check("arst post_busy", busy, 0);
        check("arst post_valid", data_valid, 0);
        e = ref_model(8'h69, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        run_frame("recover", 8'h69, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, e.d, e.perr, e.ferr, e.brk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receive engine, the next generation of the fixed 8-bit, 16x-oversampled receiver behind the APB UART. Adds runtime parity mode (none/even/odd), 1 or 2 stop bits, an input synchroniser, 3-sample majority voting, false-start rejection, and break detection. Parity checking is integrated, so no external checker is needed. Received words go into a single holding register with a valid/ready handshake and an overrun flag, ready for the APB register file to consume.

Parameters:
DATA_BITS, 8, data word width, legal 5..9
OVERSAMPLE, 16, clk cycles per bit, even, legal 8..64
CNT_W, $clog2(OVERSAMPLE), width of the tick counter (derived, not overridable)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_en  in  1  receiver enable; 0 forces IDLE at the next clk
rx  in  1  asynchronous serial input, idle high
parity_mode  in  2  0=none, 1=even, 2=odd, 3=none
stop_bits  in  1  0=one stop bit, 1=two stop bits
data_out  out  DATA_BITS  holding register, LSB = first received bit
data_valid  out  1  holding register full
data_ready  in  1  consumer accepts when data_valid&data_ready
busy  out  1  frame in progress (state != IDLE)
parity_err  out  1  parity of the held word wrong; qualified by data_valid
frame_err  out  1  a stop bit sampled 0; qualified by data_valid
overrun_err  out  1  sticky; a frame completed while data_valid=1
break_det  out  1  one-cycle pulse: data all 0, parity 0 (if enabled), stop 0

Behaviour:
- Reset: all outputs 0, data_out=0, state IDLE, synchroniser flops = 1.
- rx passes through a 2-flop synchroniser; all logic uses rx_s. Added latency: 2 clk.
- Tick counter runs 0..OVERSAMPLE-1 and wraps. Bit value = majority of rx_s at ticks M-1, M, M+1, with M=OVERSAMPLE/2. Decision is taken at tick M+1.
- IDLE: on a 1->0 edge of rx_s with rx_en=1, go to START and clear the counter.
- START: at the vote, 0 -> DATA; 1 -> IDLE (false start, no flags).
- DATA: DATA_BITS bits, LSB first, shifted into a shift register. Then PARITY if parity_mode is 1 or 2, else STOP.
- PARITY: received bit is XORed with the XOR of the data. Even mode: error if the result is 1. Odd mode: error if the result is 0.
- STOP: vote the stop bit. If stop_bits=1, take a second stop bit (STOP2). frame_err = any stop vote = 0.
- Completion happens on the clk after the final stop vote:
  - load data_out, parity_err and frame_err; set data_valid.
  - if data_valid was already 1 and not being accepted this cycle: overwrite, set overrun_err.
  - break_det pulses on break conditions.
  - state -> IDLE. IDLE can detect a new start edge immediately, which allows a half-bit-early stop.
- Handshake: data_valid clears on data_valid&data_ready. Completion and accept in the same cycle: the new word loads, data_valid stays 1, no overrun.
- overrun_err clears only by reset or by rx_en=0.
- rx_en deasserted mid-frame: abort to IDLE next clk; the partial word is discarded; the holding register is unaffected.
- Parameter/config changes mid-frame: parity_mode and stop_bits are sampled at the START->DATA transition and held for the frame.
- Latency: rx falling edge (start) to data_valid, 8N1, OVERSAMPLE=16: 2 + 9*16 + 9 + 1 = 156 clk.

Decomposition:
- Package uart_pkg: rx state enum (IDLE, START, DATA, PARITY, STOP, STOP2) and parity_mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD).
- Natural sub-module: uart_rx_sampler. It contains the synchroniser, tick counter and majority voter. It outputs rx_s, fall_edge, bit_strobe and bit_val.
- The FSM, shift register and holding register live in the top.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0x55 -> data_out=0x55, data_valid at 156 clk after the start edge, all error flags 0.
- Even parity, send 0xA5 with parity bit 1 -> parity_err=1. Same frame with parity bit 0 -> parity_err=0. Odd mode with parity bit 1 -> parity_err=0.
- 0x3C, stop bits 1 then 0 with stop_bits=1 -> frame_err=1. Then 0x00 with parity none and stop 0 -> break_det pulses once, frame_err=1.
- 6-clk low glitch on idle rx -> no state leaves IDLE after START, busy returns to 0, data_valid stays 0.
- Two back-to-back frames 0x11, 0x22 with data_ready=0 -> data_out=0x22, overrun_err=1. Then data_ready=1 for one clk -> data_valid=0, overrun_err stays 1.
- rx_en dropped at bit 4 of a frame -> busy=0 next clk, no data_valid, overrun_err cleared. Async rst_n mid-frame -> all outputs 0 immediately.
